// File: rtl/vx_arb_pkg.sv
// Shared definitions for the vx arbiter family: scan-mode encodings and index-width helper.
package vx_arb_pkg;

    localparam int ARB_MODE_CYCLIC = 0;
    localparam int ARB_MODE_RR     = 1;

    // Index width that never collapses to zero bits, so a single requester still has a port.
    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_find_first.sv
// Cyclic priority encoder: first set request at or after `start`, wrapping at NUM_REQS.
module vx_rr_find_first
    import vx_arb_pkg::*;
#(
    parameter int NUM_REQS     = 2,
    parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0]     requests,
    input  logic [LOG_NUM_REQS-1:0] start,
    output logic [LOG_NUM_REQS-1:0] index,
    output logic                    valid
);

    int                    pos;
    logic [LOG_NUM_REQS-1:0] pos_idx;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        index   = start;
        valid   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        // Walk from the farthest offset back to the nearest so the nearest hit wins last.
        for (int off = NUM_REQS - 1; off >= 0; off--) begin
            pos = int'(start) + off;
            if (pos >= NUM_REQS) begin
                pos = pos - NUM_REQS;
            end
            pos_idx = pos[LOG_NUM_REQS-1:0];
            if (requests[pos_idx]) begin
                index = pos_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_weighted_rr_arbiter.sv
// Weighted round-robin arbiter: per-requester bursts of weight+1 grants, cyclic or skip-idle scan,
// optional grant lock released by `unlock`.
module vx_weighted_rr_arbiter
    import vx_arb_pkg::*;
#(
    parameter int NUM_REQS     = 1,
    parameter int WEIGHT_W     = 4,
    parameter int MODE         = 1,
    parameter int LOCK_ENABLE  = 0,
    parameter int LOG_NUM_REQS = log2up(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          requests,
    input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
    input  logic                         unlock,
    output logic [LOG_NUM_REQS-1:0]      grant_index,
    output logic [NUM_REQS-1:0]          grant_onehot,
    output logic                         grant_valid
);

    generate
        if (NUM_REQS == 1) begin : g_single
            assign grant_index  = '0;
            assign grant_onehot = requests;
            assign grant_valid  = requests[0];

            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, reset, weights, unlock};
        end else begin : g_multi
            typedef logic [WEIGHT_W-1:0] weight_t;

            localparam logic [LOG_NUM_REQS-1:0] LAST_IDX = LOG_NUM_REQS'(NUM_REQS - 1);

            logic [LOG_NUM_REQS-1:0] ptr_r;
            logic [LOG_NUM_REQS-1:0] cand;
            logic [LOG_NUM_REQS-1:0] cand_inc;
            logic [LOG_NUM_REQS-1:0] ptr_inc;
            weight_t                 credit_r;
            weight_t                 eff_credit;
            weight_t                 cand_weight;
            weight_t                 weight_arr [NUM_REQS];
            logic                    cand_valid;
            logic                    fire;

            for (genvar i = 0; i < NUM_REQS; i++) begin : g_weights
                assign weight_arr[i] = weights[i*WEIGHT_W +: WEIGHT_W];
            end

            if (MODE == ARB_MODE_RR) begin : g_rr
                vx_rr_find_first #(
                    .NUM_REQS     (NUM_REQS),
                    .LOG_NUM_REQS (LOG_NUM_REQS)
                ) u_find_first (
                    .requests (requests),
                    .start    (ptr_r),
                    .index    (cand),
                    .valid    (cand_valid)
                );
            end else begin : g_cyclic
                assign cand       = ptr_r;
                assign cand_valid = requests[ptr_r];
            end

            // A requester that is not the current pointer owner starts a fresh burst.
            assign cand_weight = weight_arr[cand];
            assign eff_credit  = (cand == ptr_r) ? credit_r : '0;
            assign fire        = cand_valid && ((LOCK_ENABLE == 0) || unlock);
            assign cand_inc    = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            assign ptr_inc     = (ptr_r == LAST_IDX) ? '0 : ptr_r + 1'b1;

            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ptr_r    <= '0;
                    credit_r <= '0;
                end else if (fire) begin
                    if (eff_credit < cand_weight) begin
                        ptr_r    <= cand;
                        credit_r <= eff_credit + 1'b1;
                    end else begin
                        ptr_r    <= cand_inc;
                        credit_r <= '0;
                    end
                end else if (!cand_valid && (MODE == ARB_MODE_CYCLIC)) begin
                    ptr_r    <= ptr_inc;
                    credit_r <= '0;
                end
            end

            assign grant_index  = cand;
            assign grant_valid  = cand_valid;
            assign grant_onehot = cand_valid ? (NUM_REQS'(1) << cand) : '0;
        end
    endgenerate

endmodule

// File: tb/tb_vx_weighted_rr_arbiter.sv
// Self-checking bench: four arbiter configurations against a grant-accounting reference model.
module tb_vx_weighted_rr_arbiter;

    typedef struct {
        int start;
        int used;
    } model_t;

    localparam model_t MODEL_RESET = '{start: 0, used: 0};

    logic clk;
    logic reset;

    logic [3:0]  rr_req, lk_req;
    logic [15:0] rr_w, lk_w;
    logic        lk_unlock;
    logic [1:0]  rr_idx, lk_idx;
    logic [3:0]  rr_oh, lk_oh;
    logic        rr_valid, lk_valid;

    logic [2:0]  cy_req;
    logic [11:0] cy_w;
    logic [1:0]  cy_idx;
    logic [2:0]  cy_oh;
    logic        cy_valid;

    logic [0:0]  one_req;
    logic [3:0]  one_w;
    logic        one_unlock;
    logic [0:0]  one_idx;
    logic [0:0]  one_oh;
    logic        one_valid;

    model_t m_rr, m_lk, m_cy;
    int     tests;
    int     fails;

    vx_weighted_rr_arbiter #(.NUM_REQS(4), .WEIGHT_W(4), .MODE(1), .LOCK_ENABLE(0)) u_rr (
        .clk (clk), .reset (reset), .requests (rr_req), .weights (rr_w), .unlock (1'b0),
        .grant_index (rr_idx), .grant_onehot (rr_oh), .grant_valid (rr_valid)
    );

    vx_weighted_rr_arbiter #(.NUM_REQS(4), .WEIGHT_W(4), .MODE(1), .LOCK_ENABLE(1)) u_lk (
        .clk (clk), .reset (reset), .requests (lk_req), .weights (lk_w), .unlock (lk_unlock),
        .grant_index (lk_idx), .grant_onehot (lk_oh), .grant_valid (lk_valid)
    );

    vx_weighted_rr_arbiter #(.NUM_REQS(3), .WEIGHT_W(4), .MODE(0), .LOCK_ENABLE(0)) u_cy (
        .clk (clk), .reset (reset), .requests (cy_req), .weights (cy_w), .unlock (1'b0),
        .grant_index (cy_idx), .grant_onehot (cy_oh), .grant_valid (cy_valid)
    );

    vx_weighted_rr_arbiter #(.NUM_REQS(1), .WEIGHT_W(4), .MODE(1), .LOCK_ENABLE(1)) u_one (
        .clk (clk), .reset (reset), .requests (one_req), .weights (one_w), .unlock (one_unlock),
        .grant_index (one_idx), .grant_onehot (one_oh), .grant_valid (one_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Who gets the grant: the model scans requesters in order starting from the slot it last left.
    function automatic void model_out(input model_t m, input int n, input int mode,
                                      input logic [3:0] req, output int idx, output int vld);
        idx = m.start;
        vld = 0;
        if (mode == 1) begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (m.start + k) % n;
                if (req[j] && vld == 0) begin
                    idx = j;
                    vld = 1;
                end
            end
        end else begin
            vld = int'(req[m.start]);
        end
    endfunction

    // A burst allows weight+1 grants; once used up, the slot after the owner is next in line.
    function automatic model_t model_next(input model_t m, input int n, input int mode, input int lock,
                                          input logic [3:0] req, input logic [15:0] w, input logic unl);
        model_t r;
        int     idx, vld, used, allow;
        r = m;
        model_out(m, n, mode, req, idx, vld);
        if (vld != 0 && (lock == 0 || unl)) begin
            used  = ((idx == m.start) ? m.used : 0) + 1;
            allow = int'(w[idx*4 +: 4]) + 1;
            if (used < allow) begin
                r.start = idx;
                r.used  = used;
            end else begin
                r.start = (idx + 1) % n;
                r.used  = 0;
            end
        end else if (vld == 0 && mode == 0) begin
            r.start = (m.start + 1) % n;
            r.used  = 0;
        end
        return r;
    endfunction

    task automatic compare_all();
        int idx, vld;
        #1;
        model_out(m_rr, 4, 1, rr_req, idx, vld);
        check("rr_index", rr_idx, idx);
        check("rr_valid", rr_valid, vld);
        check("rr_onehot", rr_oh, (vld != 0) ? (1 << idx) : 0);
        model_out(m_lk, 4, 1, lk_req, idx, vld);
        check("lk_index", lk_idx, idx);
        check("lk_valid", lk_valid, vld);
        check("lk_onehot", lk_oh, (vld != 0) ? (1 << idx) : 0);
        model_out(m_cy, 3, 0, {1'b0, cy_req}, idx, vld);
        check("cy_index", cy_idx, idx);
        check("cy_valid", cy_valid, vld);
        check("cy_onehot", cy_oh, (vld != 0) ? (1 << idx) : 0);
        check("one_index", one_idx, 0);
        check("one_valid", one_valid, one_req[0]);
        check("one_onehot", one_oh, one_req);
    endtask

    task automatic tick();
        m_rr = model_next(m_rr, 4, 1, 0, rr_req, rr_w, 1'b0);
        m_lk = model_next(m_lk, 4, 1, 1, lk_req, lk_w, lk_unlock);
        m_cy = model_next(m_cy, 3, 0, 0, {1'b0, cy_req}, {4'h0, cy_w}, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_rr  = MODEL_RESET;
        m_lk  = MODEL_RESET;
        m_cy  = MODEL_RESET;
        compare_all();
        reset = 1'b1;
    endtask

    function automatic logic [15:0] rand_weights();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) begin
            w[i*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        end
        return w;
    endfunction

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b0;
        rr_req     = '0;
        rr_w       = '0;
        lk_req     = '0;
        lk_w       = '0;
        lk_unlock  = 1'b0;
        cy_req     = '0;
        cy_w       = '0;
        one_req    = '0;
        one_w      = 4'h3;
        one_unlock = 1'b0;
        m_rr       = MODEL_RESET;
        m_lk       = MODEL_RESET;
        m_cy       = MODEL_RESET;
        @(posedge clk);
        #1;

        // Equal weights, all requesting: plain rotation.
        do_reset();
        rr_req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            compare_all();
            check("s1_rotation", rr_idx, i % 4);
            check("s1_valid", rr_valid, 1);
            tick();
        end

        // Requester 1 weighted 2 gets three grants per turn.
        do_reset();
        rr_w   = 16'h0020;
        rr_req = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            compare_all();
            check("s2_burst", rr_idx, (i % 4 == 0) ? 0 : 1);
            tick();
        end
        rr_req = '0;

        // Lock holds the grant until a one-cycle unlock pulse.
        do_reset();
        lk_req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            compare_all();
            check("s3_locked", lk_idx, 0);
            tick();
        end
        lk_unlock = 1'b1;
        compare_all();
        check("s3_unlock_cycle", lk_idx, 0);
        tick();
        lk_unlock = 1'b0;
        compare_all();
        check("s3_after_unlock", lk_idx, 2);
        tick();
        lk_req = '0;

        // Cyclic slotting on three requesters with only requester 1 active.
        do_reset();
        cy_req = 3'b010;
        for (int i = 0; i < 5; i++) begin
            compare_all();
            check("s4_slot", cy_idx, i % 3);
            check("s4_valid", cy_valid, (i % 3 == 1) ? 1 : 0);
            check("s4_onehot", cy_oh, (i % 3 == 1) ? 2 : 0);
            tick();
        end
        cy_req = '0;

        // Owner drops mid-burst; on return it earns a full fresh burst.
        do_reset();
        rr_w   = 16'h0300;
        rr_req = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            compare_all();
            check("s5_first_burst", rr_idx, 2);
            tick();
        end
        rr_req = 4'b1000;
        compare_all();
        check("s5_switch", rr_idx, 3);
        tick();
        rr_req = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            compare_all();
            check("s5_full_burst", rr_idx, (i < 4) ? 2 : 3);
            tick();
        end

        // Asynchronous reset in the middle of a burst.
        do_reset();
        rr_w   = 16'h0020;
        rr_req = 4'b0110;
        compare_all();
        check("s6_pre_reset", rr_idx, 1);
        tick();
        reset = 1'b0;
        m_rr  = MODEL_RESET;
        m_lk  = MODEL_RESET;
        m_cy  = MODEL_RESET;
        compare_all();
        check("s6_in_reset", rr_idx, 1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            compare_all();
            check("s6_resume", rr_idx, (i < 3) ? 1 : 2);
            tick();
        end

        // Maximum weight yields 2^WEIGHT_W consecutive grants.
        do_reset();
        rr_w   = 16'h000F;
        rr_req = 4'b0011;
        for (int i = 0; i < 17; i++) begin
            compare_all();
            check("s7_max_weight", rr_idx, (i < 16) ? 0 : 1);
            tick();
        end

        // Random traffic, weights changing mid-burst, random unlock pulses.
        do_reset();
        rr_w = rand_weights();
        lk_w = rand_weights();
        cy_w = rand_weights()[11:0];
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 2) == 0) rr_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) lk_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) cy_req = 3'($urandom_range(0, 7));
            one_req    = 1'($urandom_range(0, 1));
            one_unlock = 1'($urandom_range(0, 1));
            lk_unlock  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) rr_w = rand_weights();
            if ($urandom_range(0, 7) == 0) lk_w = rand_weights();
            if ($urandom_range(0, 7) == 0) cy_w = rand_weights()[11:0];
            compare_all();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
